pool_layer_mm: RTL
==================

# pool_layer_mm

Parametrised multi-mode pooling layer for the CIM inference pipeline: streams pixels from all channels in raster order, computes non-overlapping kernel_dim×kernel_dim max or average pooling per channel, and hands one result vector per window to the next layer with backpressure. It replaces the fixed max-only pool stage between convolution and FC layers, and adds selectable mode, non-power-of-two image widths, frame done signalling and input backpressure.

## Interface
- input_channels, 6: channels processed in parallel
- img_width, 24: square input image width/height in pixels
- kernel_dim, 2: window size and stride; must be 1, 2, 4 or 8
- datatype_size, 4: unsigned input pixel width
- output_datatype_size, 4: output width; results are truncated to the low bits
- clk  input  1  clock, all logic rising-edge
- rst  input  1  asynchronous, active-low reset
- i_start  input  1  frame start pulse
- i_mode  input  1  0 = max, 1 = average; sampled on the accepted i_start
- i_ibuf_we  input  1  pixel write strobe, all channels together
- i_ibuf_wr_data  input  datatype_size × [input_channels]  pixel per channel
- i_next_busy  input  1  downstream cannot accept
- o_busy  output  1  upstream must not write
- o_func_valid  output  1  result present
- o_func_data  output  output_datatype_size × [input_channels]  pooled result
- o_done  output  1  one-cycle pulse, frame complete
- o_overflow  output  1  sticky: a write was dropped

## Operation
- Derived: ow = img_width / kernel_dim (floor); acc width = datatype_size + 2·$clog2(kernel_dim); shift = 2·$clog2(kernel_dim).
- States: IDLE, RUN, FLUSH.
- IDLE: writes ignored (no overflow). i_start → RUN; clears row/col counters, all ow×input_channels accumulators, latches i_mode.
- RUN: each accepted write (i_ibuf_we & !o_busy) updates accumulator [col/kernel_dim][ch] (max: larger of stored and pixel; avg: add), then advances col; col wraps img_width-1 → 0 with row+1.
- Pixels with col ≥ ow·kernel_dim or row ≥ ow·kernel_dim are accepted but do not touch accumulators.
- First pixel of a window (row%k==0, col%k==0) loads rather than combines.
- Window complete when row%k==k-1 and col%k==k-1 inside the valid region: result = max value, or acc >> shift for average; registered into o_func_data, o_func_valid set.
- Last pixel (row = col = img_width-1) accepted → FLUSH.
- FLUSH: when o_func_valid is 0 (or is consumed this cycle) pulse o_done, → IDLE.
- i_start in RUN/FLUSH: restart as from IDLE; pending o_func_valid cleared; no o_done.
- o_busy = o_func_valid & i_next_busy, in RUN only. Write while o_busy high is dropped, sets o_overflow; o_overflow cleared only by reset or i_start.
- kernel_dim = 1: every pixel is a window; output equals input (both modes).

## Timing
- Reset: state IDLE, counters 0, accumulators 0, o_func_valid 0, o_func_data all 0, o_busy 0, o_done 0, o_overflow 0.
- Latency: o_func_valid rises the cycle after the window-completing write is accepted.
- Consumption: result taken on any cycle o_func_valid & !i_next_busy; o_func_valid drops next cycle unless a new window completes that same cycle, in which case valid stays high with new data.
- o_func_data stable while o_func_valid & i_next_busy.
- o_busy is combinational from registered o_func_valid and i_next_busy.
- o_done: one cycle, the cycle after the final result is consumed (or after entering FLUSH with nothing pending).
- Back-to-back writes every cycle sustained when i_next_busy low.

## Test plan
- 4×4, 1 ch, k=2, max, pixels 0..15 raster → outputs 5, 7, 13, 15 in order, then o_done.
- Same frame, average → outputs 2 (10>>2), 4, 10, 12; all-15 frame → 15 ×4, no width overflow.
- Backpressure: hold i_next_busy high after first result → o_busy high, o_func_data holds 5; write while busy → dropped, o_overflow=1; release → stream resumes, o_overflow stays 1 until i_start.
- img_width=5, k=2, 1 ch: 25 pixels → exactly 4 results (row/col 4 ignored), o_done after 25th write.
- i_start after 6 writes → pending valid cleared, counters reset, next full frame gives correct results, no stray o_done.
- Assert rst low mid-frame with o_func_valid high → all outputs 0 immediately; writes ignored until next i_start.

Source files
------------

// File: rtl/pool_layer_mm.sv
// Streaming per-channel max/average pooling over non-overlapping kernel_dim x kernel_dim
// windows; one result vector per completed window, handed downstream with backpressure.
module pool_layer_mm #(
  parameter int input_channels       = 6,
  parameter int img_width            = 24,
  parameter int kernel_dim           = 2,
  parameter int datatype_size        = 4,
  parameter int output_datatype_size = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 i_start,
  input  logic                                                 i_mode,
  input  logic                                                 i_ibuf_we,
  input  logic [input_channels-1:0][datatype_size-1:0]         i_ibuf_wr_data,
  input  logic                                                 i_next_busy,
  output logic                                                 o_busy,
  output logic                                                 o_func_valid,
  output logic [input_channels-1:0][output_datatype_size-1:0]  o_func_data,
  output logic                                                 o_done,
  output logic                                                 o_overflow
);
  localparam int KLOG  = $clog2(kernel_dim);
  localparam int SHIFT = 2 * KLOG;
  localparam int ACC_W = datatype_size + SHIFT;
  localparam int OUT_W = output_datatype_size;
  localparam int OW    = img_width / kernel_dim;
  localparam int CW    = $clog2(img_width + 1);
  localparam int WIN_W = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [CW-1:0] LAST    = CW'(img_width - 1);
  localparam logic [CW-1:0] VAL_END = CW'(OW * kernel_dim);
  localparam logic [CW-1:0] KMASK   = CW'(kernel_dim - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e           state_q;
  logic [CW-1:0]    row_q, col_q;
  logic             avg_q;
  logic [ACC_W-1:0] acc_q [OW][input_channels];

  logic                                 accept, consume;
  logic                                 in_region, win_first, win_last, frame_last;
  logic [WIN_W-1:0]                     win_idx;
  logic [ACC_W-1:0]                     acc_d [input_channels];
  logic [input_channels-1:0][OUT_W-1:0] res_d;

  assign o_busy     = (state_q == RUN) & o_func_valid & i_next_busy;
  assign accept     = (state_q == RUN) & i_ibuf_we & ~o_busy;
  assign consume    = o_func_valid & ~i_next_busy;
  assign in_region  = (row_q < VAL_END) && (col_q < VAL_END);
  assign win_first  = ((row_q & KMASK) == '0) && ((col_q & KMASK) == '0);
  assign win_last   = ((row_q & KMASK) == KMASK) && ((col_q & KMASK) == KMASK);
  assign frame_last = (row_q == LAST) && (col_q == LAST);
  assign win_idx    = WIN_W'(col_q >> KLOG);

  // NOTE: acc_d/res_d get a value on every path through the loop, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < input_channels; c++) begin
      acc_d[c] = ACC_W'(i_ibuf_wr_data[c]);
      if (!win_first) begin
        if (avg_q) acc_d[c] = acc_q[win_idx][c] + ACC_W'(i_ibuf_wr_data[c]);
        else if (acc_q[win_idx][c] > acc_d[c]) acc_d[c] = acc_q[win_idx][c];
      end
      res_d[c] = avg_q ? OUT_W'(acc_d[c] >> SHIFT) : OUT_W'(acc_d[c]);
    end
  end

  // NOTE: state is updated only with <= so every read in this block sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      avg_q        <= 1'b0;
      o_func_valid <= 1'b0;
      o_func_data  <= '0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      // NOTE: the accumulator array is small and must read as zero after reset, so it is reset.
      for (int w = 0; w < OW; w++)
        for (int c = 0; c < input_channels; c++)
          acc_q[w][c] <= '0;
    end else begin
      o_done <= 1'b0;
      if (consume) o_func_valid <= 1'b0;

      if (i_start) begin
        state_q      <= RUN;
        row_q        <= '0;
        col_q        <= '0;
        avg_q        <= i_mode;
        o_func_valid <= 1'b0;
        o_overflow   <= 1'b0;
        for (int w = 0; w < OW; w++)
          for (int c = 0; c < input_channels; c++)
            acc_q[w][c] <= '0;
      end else begin
        case (state_q)
          RUN: begin
            if (i_ibuf_we && o_busy) o_overflow <= 1'b1;
            if (accept) begin
              if (in_region) begin
                for (int c = 0; c < input_channels; c++) acc_q[win_idx][c] <= acc_d[c];
                if (win_last) begin
                  o_func_data  <= res_d;
                  o_func_valid <= 1'b1;
                end
              end
              if (col_q == LAST) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
              if (frame_last) state_q <= FLUSH;
            end
          end
          FLUSH: begin
            // Frame ends once the last result has left (or nothing was pending).
            if (!o_func_valid || consume) begin
              o_done  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
